// File: rtl/led_sweeper_if.sv
// Control and display signals of the LED pattern generator.
// The controller drives en/mode; the sweeper drives the LED bank and status.
interface led_sweeper_if #(
  parameter int N = 8
);
  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] led_out;
  logic         dir;
  logic         step;

  modport master (
    output en,
    output mode,
    input  led_out,
    input  dir,
    input  step
  );

  modport slave (
    input  en,
    input  mode,
    output led_out,
    output dir,
    output step
  );
endinterface

// File: rtl/led_sweeper.sv
// N-wide LED pattern generator: prescaled step tick driving one of four patterns.
//
// state    | meaning
// M_FILL   | bar grows from bit 0 to all-ones, then shrinks back to bit 0
// M_SCAN   | single lit bit bounces between bit 0 and bit N-1
// M_ROTATE | lit pattern rotates toward the MSB, wrapping to bit 0
// M_BLINK  | whole bank inverts on every step
module led_sweeper #(
  parameter int N   = 8,
  parameter int DIV = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  led_sweeper_if.slave   bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] MSB  = ONE << (N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    M_FILL   = 2'd0,
    M_SCAN   = 2'd1,
    M_ROTATE = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  mode_t         mode_q, mode_d, mode_in;
  logic [N-1:0]  led_q, led_d, led_n;
  logic          dir_q, dir_d, dir_n;
  logic          step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign mode_in = mode_t'(bus.mode);
  assign tick    = bus.en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode_in;
      led_q  <= ONE;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  // Pattern one step ahead of the current one, for the latched mode.
  always_comb begin
    led_n = led_q;
    dir_n = 1'b0;
    unique case (mode_q)
      M_FILL: begin
        if (!dir_q) begin
          led_n = (led_q << 1) | ONE;
          dir_n = (led_n == ONES);
        end else begin
          led_n = led_q >> 1;
          dir_n = (led_n != ONE);
        end
      end
      M_SCAN: begin
        if (!dir_q) begin
          led_n = led_q << 1;
          dir_n = (led_n == MSB);
        end else begin
          led_n = led_q >> 1;
          dir_n = (led_n != ONE);
        end
      end
      M_ROTATE: begin
        led_n = (led_q << 1) | (led_q >> (N - 1));
        dir_n = 1'b0;
      end
      M_BLINK: begin
        led_n = ~led_q;
        dir_n = 1'b0;
      end
      default: begin
        led_n = led_q;
        dir_n = 1'b0;
      end
    endcase
    // A single LED has nowhere to move; only BLINK changes it.
    if (N == 1 && mode_q != M_BLINK) begin
      led_n = ONE;
      dir_n = 1'b0;
    end
  end

  // Mode reload outranks a coincident tick and ignores en.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    cnt_d  = cnt_q;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      led_d  = (mode_in == M_BLINK) ? ONES : ONE;
      dir_d  = 1'b0;
      cnt_d  = '0;
    end else if (bus.en) begin
      if (tick) begin
        cnt_d  = '0;
        led_d  = led_n;
        dir_d  = dir_n;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign bus.led_out = led_q;
  assign bus.dir     = dir_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_led_sweeper.sv
// Bench for led_sweeper: three configurations against a step-index pattern model
// plus directed literal expectations for the documented scenarios.
module tb_led_sweeper;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  always #5 clk = ~clk;

  led_sweeper_if #(.N(8)) if0 ();
  led_sweeper_if #(.N(8)) if1 ();
  led_sweeper_if #(.N(5)) if2 ();

  led_sweeper #(.N(8), .DIV(4)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  led_sweeper #(.N(8), .DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  led_sweeper #(.N(5), .DIV(3)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  // Model state: the pattern is a function of steps taken since the last
  // reset/reload; the prescaler is a count of enabled cycles.
  int          m_n[3]     = '{8, 8, 5};
  int          m_div[3]   = '{4, 1, 3};
  bit          m_valid[3] = '{0, 0, 0};
  int          m_mode[3];
  int          m_k[3];
  int          m_cnt[3];
  bit          m_step[3];
  logic [31:0] m_base[3];

  function automatic logic [31:0] mask_of(int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] exp_led(int n, int md, int k, logic [31:0] base);
    int per, p, c;
    if (md == 3) return ((k % 2) == 0) ? base : (~base & mask_of(n));
    if (n == 1) return 32'd1;
    if (md == 2) return 32'd1 << (k % n);
    per = 2 * (n - 1);
    p = k % per;
    if (md == 0) begin
      c = (p <= n - 1) ? p + 1 : 2 * n - 1 - p;
      return mask_of(c);
    end
    c = (p <= n - 1) ? p : per - p;
    return 32'd1 << c;
  endfunction

  function automatic bit exp_dir(int n, int md, int k);
    int p;
    if (md >= 2 || n == 1) return 1'b0;
    p = k % (2 * (n - 1));
    return (p >= n - 1);
  endfunction

  task automatic model_edge(input int i, input logic r, input logic e, input logic [1:0] md);
    if (r) begin
      m_valid[i] = 1'b1;
      m_mode[i]  = int'(md);
      m_k[i]     = 0;
      m_cnt[i]   = 0;
      m_step[i]  = 1'b0;
      m_base[i]  = 32'd1;
    end else if (m_valid[i]) begin
      if (int'(md) != m_mode[i]) begin
        m_mode[i] = int'(md);
        m_k[i]    = 0;
        m_cnt[i]  = 0;
        m_step[i] = 1'b0;
        m_base[i] = (md == 2'd3) ? mask_of(m_n[i]) : 32'd1;
      end else if (e) begin
        if (m_cnt[i] == m_div[i] - 1) begin
          m_cnt[i]  = 0;
          m_k[i]    = m_k[i] + 1;
          m_step[i] = 1'b1;
        end else begin
          m_cnt[i]  = m_cnt[i] + 1;
          m_step[i] = 1'b0;
        end
      end else begin
        m_step[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, rst0, if0.en, if0.mode);
    model_edge(1, rst1, if1.en, if1.mode);
    model_edge(2, rst2, if2.en, if2.mode);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [31:0] a_led;
  logic        a_dir, a_step;

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i]) begin
          case (i)
            0:       begin a_led = 32'(if0.led_out); a_dir = if0.dir; a_step = if0.step; end
            1:       begin a_led = 32'(if1.led_out); a_dir = if1.dir; a_step = if1.step; end
            default: begin a_led = 32'(if2.led_out); a_dir = if2.dir; a_step = if2.step; end
          endcase
          chk($sformatf("model%0d led", i), a_led,
              exp_led(m_n[i], m_mode[i], m_k[i], m_base[i]));
          chk($sformatf("model%0d dir", i), 32'(a_dir),
              32'(exp_dir(m_n[i], m_mode[i], m_k[i])));
          chk($sformatf("model%0d step", i), 32'(a_step), 32'(m_step[i]));
        end
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] fill_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h03};
  logic [7:0] scan_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [4:0] rot_seq [5]   = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01};

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.en = 1'b1; if1.en = 1'b1; if2.en = 1'b1;
    if0.mode = 2'd0; if1.mode = 2'd1; if2.mode = 2'd2;

    // FILL, N=8, DIV=4
    tick_n(1);
    chk("fill reset led", 32'(if0.led_out), 32'h01);
    chk("fill reset dir", 32'(if0.dir), 32'd0);
    chk("fill reset step", 32'(if0.step), 32'd0);
    rst0 = 1'b0;
    for (int s = 1; s < 16; s++) begin
      tick_n(3);
      chk("fill hold step", 32'(if0.step), 32'd0);
      tick_n(1);
      chk($sformatf("fill led[%0d]", s), 32'(if0.led_out), 32'(fill_seq[s]));
      chk($sformatf("fill dir[%0d]", s), 32'(if0.dir), (s >= 7 && s <= 13) ? 32'd1 : 32'd0);
      chk("fill step", 32'(if0.step), 32'd1);
    end

    // Reset mid-pattern at 3F / dir 1
    rst0 = 1'b1;
    tick_n(1);
    rst0 = 1'b0;
    tick_n(36);
    chk("pre-rst led", 32'(if0.led_out), 32'h3F);
    chk("pre-rst dir", 32'(if0.dir), 32'd1);
    rst0 = 1'b1;
    tick_n(1);
    rst0 = 1'b0;
    chk("rst led", 32'(if0.led_out), 32'h01);
    chk("rst dir", 32'(if0.dir), 32'd0);
    chk("rst step", 32'(if0.step), 32'd0);
    tick_n(4);
    chk("restart led", 32'(if0.led_out), 32'h03);
    chk("restart step", 32'(if0.step), 32'd1);

    // Freeze at 0F one cycle into the count
    tick_n(8);
    chk("freeze start led", 32'(if0.led_out), 32'h0F);
    tick_n(1);
    if0.en = 1'b0;
    tick_n(10);
    chk("frozen led", 32'(if0.led_out), 32'h0F);
    chk("frozen step", 32'(if0.step), 32'd0);
    if0.en = 1'b1;
    tick_n(2);
    chk("resume hold led", 32'(if0.led_out), 32'h0F);
    tick_n(1);
    chk("resume led", 32'(if0.led_out), 32'h1F);
    chk("resume step", 32'(if0.step), 32'd1);

    // Mode change coincident with a tick
    tick_n(3);
    if0.mode = 2'd1;
    tick_n(1);
    chk("reload led", 32'(if0.led_out), 32'h01);
    chk("reload dir", 32'(if0.dir), 32'd0);
    chk("reload step", 32'(if0.step), 32'd0);
    tick_n(3);
    chk("post-reload hold", 32'(if0.led_out), 32'h01);
    tick_n(1);
    chk("post-reload led", 32'(if0.led_out), 32'h02);
    chk("post-reload step", 32'(if0.step), 32'd1);

    // SCAN, N=8, DIV=1
    rst1 = 1'b0;
    for (int s = 0; s < 16; s++) begin
      tick_n(1);
      chk($sformatf("scan led[%0d]", s), 32'(if1.led_out), 32'(scan_seq[s]));
      chk("scan step", 32'(if1.step), 32'd1);
    end

    // ROTATE then BLINK, N=5, DIV=3
    rst2 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick_n(3);
      chk($sformatf("rot led[%0d]", s), 32'(if2.led_out), 32'(rot_seq[s]));
      chk("rot dir", 32'(if2.dir), 32'd0);
    end
    if2.mode = 2'd3;
    tick_n(1);
    chk("blink reload led", 32'(if2.led_out), 32'h1F);
    chk("blink reload step", 32'(if2.step), 32'd0);
    tick_n(3);
    chk("blink led 0", 32'(if2.led_out), 32'h00);
    chk("blink step", 32'(if2.step), 32'd1);
    tick_n(3);
    chk("blink led 1", 32'(if2.led_out), 32'h1F);

    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
